pengendali_perkalian_matrix: RTL and testbench

Sequencer for the 3x3 matrix-multiply datapath (perkalian_matrix, one dot product of a row of A and a column of B per issue).
- Holds operand matrices A and B and result matrix C in local register files.
- On a start pulse, issues all 9 row/column pairs in row-major order and captures each datapath result into C after a fixed latency.
- Signals done; C is read back through a simple read port.

---
 rtl/pengendali_perkalian_matrix.sv | 196 +++++++++++++++++++
 tb/tb_pengendali_perkalian_matrix.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pengendali_perkalian_matrix.sv
`default_nettype none
// ============================================================================
// Module      : pengendali_perkalian_matrix
// Description : 3x3 matrix-multiply sequencer. Holds A, B and C, issues the
//               nine row/column pairs to the external dot-product datapath
//               and captures each result into C after DP_LATENCY cycles.
//               Optional macro PERKALIAN_ACC_EN adds acc_mode (C += result).
// Revision    : 1.0 - initial release
// ============================================================================
module pengendali_perkalian_matrix #(
  parameter int DATA_W     = 16,
  parameter int DP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
`ifdef PERKALIAN_ACC_EN
  input  logic              acc_mode,
`endif
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dp_col_a,
  output logic [DATA_W-1:0] dp_col_b,
  output logic [DATA_W-1:0] dp_col_c,
  output logic [DATA_W-1:0] dp_row_a,
  output logic [DATA_W-1:0] dp_row_b,
  output logic [DATA_W-1:0] dp_row_c,
  input  logic [DATA_W-1:0] dp_keluaran
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_a [9];
  logic [DATA_W-1:0] r_b [9];
  logic [DATA_W-1:0] r_c [9];
  logic [1:0]        r_row;
  logic [1:0]        r_col;
  logic [3:0]        w_abase;
  logic [3:0]        w_k;
  logic [3:0]        w_b_idx;
  logic              w_issue;
  logic              w_cap_vld;
  logic [3:0]        w_cap_idx;
  logic [DATA_W-1:0] w_cap_val;

  assign w_issue = (r_state == S_ISSUE);
  assign w_abase = {1'b0, r_row, 1'b0} + {2'b00, r_row};
  assign w_k     = w_abase + {2'b00, r_col};
  // 9..17 maps onto 0..8 through the low nibble modulo 16
  assign w_b_idx = wr_addr[3:0] - 4'd9;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= 2'd0;
      r_col   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        if (r_col == 2'd2) begin
          r_col <= 2'd0;
          r_row <= r_row + 2'd1;
        end else begin
          r_col <= r_col + 2'd1;
        end
      end else begin
        r_row <= 2'd0;
        r_col <= 2'd0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (w_k == 4'd8) w_next = (DP_LATENCY == 0) ? S_FIN : S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_cap_vld && (w_cap_idx == 4'd8)) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dp_col_a = '0;
    dp_col_b = '0;
    dp_col_c = '0;
    dp_row_a = '0;
    dp_row_b = '0;
    dp_row_c = '0;
    if (w_issue) begin
      dp_col_a = r_a[w_abase];
      dp_col_b = r_a[w_abase + 4'd1];
      dp_col_c = r_a[w_abase + 4'd2];
      dp_row_a = r_b[{2'b00, r_col}];
      dp_row_b = r_b[{2'b00, r_col} + 4'd3];
      dp_row_c = r_b[{2'b00, r_col} + 4'd6];
    end
  end

  // Operand writes only land while idle, so a run always sees stable A/B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
      end
    end else if ((r_state == S_IDLE) && wr_en) begin
      if (wr_addr < 5'd9) begin
        r_a[wr_addr[3:0]] <= wr_data;
      end else if (wr_addr < 5'd18) begin
        r_b[w_b_idx] <= wr_data;
      end
    end
  end

  generate
    if (DP_LATENCY == 0) begin : g_lat0
      assign w_cap_vld = w_issue;
      assign w_cap_idx = w_k;
    end else begin : g_latn
      logic       r_sv [DP_LATENCY];
      logic [3:0] r_si [DP_LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int n = 0; n < DP_LATENCY; n++) begin
            r_sv[n] <= 1'b0;
            r_si[n] <= 4'd0;
          end
        end else begin
          r_sv[0] <= w_issue;
          r_si[0] <= w_k;
          for (int n = 1; n < DP_LATENCY; n++) begin
            r_sv[n] <= r_sv[n-1];
            r_si[n] <= r_si[n-1];
          end
        end
      end

      assign w_cap_vld = r_sv[DP_LATENCY-1];
      assign w_cap_idx = r_si[DP_LATENCY-1];
    end
  endgenerate

`ifdef PERKALIAN_ACC_EN
  logic r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_acc <= acc_mode;
    end
  end

  assign w_cap_val = r_acc ? (r_c[w_cap_idx] + dp_keluaran) : dp_keluaran;
`else
  assign w_cap_val = dp_keluaran;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) r_c[n] <= '0;
    end else if (w_cap_vld) begin
      r_c[w_cap_idx] <= w_cap_val;
    end
  end

  assign rd_data = (rd_addr < 4'd9) ? r_c[rd_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pengendali_perkalian_matrix.sv
`default_nettype none
// ============================================================================
// Module      : tb_pengendali_perkalian_matrix
// Description : Self-checking bench: table vectors, corner sequences and
//               random matrices against a plain matrix-product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pengendali_perkalian_matrix;
  localparam int DW  = 16;
  localparam int LAT = 1;

  typedef struct packed {
    logic [8:0][DW-1:0] a;
    logic [8:0][DW-1:0] b;
    logic [8:0][DW-1:0] c;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          acc_mode = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic          busy, done;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dp_col_a, dp_col_b, dp_col_c, dp_row_a, dp_row_b, dp_row_c;
  logic [DW-1:0] dp_keluaran;
  logic [DW-1:0] dp_q = '0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ma [9];
  logic [DW-1:0] mb [9];
  logic [DW-1:0] mc [9];
  vec_t          tbl [3];

  pengendali_perkalian_matrix #(.DATA_W(DW), .DP_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start),
`ifdef PERKALIAN_ACC_EN
    .acc_mode(acc_mode),
`endif
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_col_a(dp_col_a), .dp_col_b(dp_col_b), .dp_col_c(dp_col_c),
    .dp_row_a(dp_row_a), .dp_row_b(dp_row_b), .dp_row_c(dp_row_c),
    .dp_keluaran(dp_keluaran)
  );

  always #5 clk = ~clk;

  // External dot-product datapath with one cycle of latency
  always @(posedge clk)
    dp_q <= DW'(dp_col_a * dp_row_a + dp_col_b * dp_row_b + dp_col_c * dp_row_c);
  assign dp_keluaran = dp_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_product();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        logic [DW-1:0] s = '0;
        for (int t = 0; t < 3; t++) s = DW'(s + ma[3*i+t] * mb[3*t+j]);
        mc[3*i+j] = s;
      end
  endtask

  task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < 9) ma[a] = d;
    else if (a < 18) mb[a-9] = d;
  endtask

  task automatic load_model();
    for (int n = 0; n < 9; n++) wr(5'(n), ma[n]);
    for (int n = 0; n < 9; n++) wr(5'(n + 9), mb[n]);
    model_product();
  endtask

  task automatic check_c(input string tag);
    for (int n = 0; n < 16; n++) begin
      rd_addr = 4'(n); #1;
      chk($sformatf("%s_c%0d", tag, n), 64'(rd_data), (n < 9) ? 64'(mc[n]) : 64'd0);
    end
  endtask

  // One run: start edge, then 16 monitored cycles with optional disturbances
  task automatic run(input int restart_cyc, input int wr_cyc, input int rst_cyc, input bit tp_dp);
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, dp_err = 0;
    bit aborted = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      start = (cyc == restart_cyc);
      wr_en = (cyc == wr_cyc); wr_addr = 5'd0; wr_data = 16'h00FF;
      rst = (cyc == rst_cyc);
      if (cyc == rst_cyc) begin
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dp", {dp_col_a, dp_col_b, dp_col_c}, 64'd0);
        chk("rst_dp_row", {dp_row_a, dp_row_b, dp_row_c}, 64'd0);
        aborted = 1'b1;
        for (int n = 0; n < 9; n++) begin ma[n] = '0; mb[n] = '0; mc[n] = '0; end
      end
      #1;
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (!aborted && cyc <= 9) begin
        int i = (cyc - 1) / 3, j = (cyc - 1) % 3;
        if ({dp_col_a, dp_col_b, dp_col_c} !== {ma[3*i], ma[3*i+1], ma[3*i+2]} ||
            {dp_row_a, dp_row_b, dp_row_c} !== {mb[j], mb[j+3], mb[j+6]}) dp_err++;
      end else if ({dp_col_a, dp_col_b, dp_col_c, dp_row_a, dp_row_b, dp_row_c} !== '0) dp_err++;
      if (tp_dp && cyc == 1) begin
        chk("dp_col_c1", {dp_col_a, dp_col_b, dp_col_c}, {16'd1, 16'd0, 16'd0});
        chk("dp_row_c1", {dp_row_a, dp_row_b, dp_row_c}, {16'd1, 16'd4, 16'd7});
      end
      if (tp_dp && cyc == 9) begin
        chk("dp_col_c9", {dp_col_a, dp_col_b, dp_col_c}, {16'd0, 16'd0, 16'd1});
        chk("dp_row_c9", {dp_row_a, dp_row_b, dp_row_c}, {16'd3, 16'd6, 16'd9});
      end
      @(posedge clk); #1;
    end
    start = 1'b0; wr_en = 1'b0; rst = 1'b0;
    chk("done_pulses", 64'(done_cnt), aborted ? 64'd0 : 64'd1);
    chk("busy_cycles", 64'(busy_cnt), aborted ? 64'(rst_cyc - 1) : 64'(9 + LAT));
    chk("dp_stream_err", 64'(dp_err), 64'd0);
    if (!aborted) chk("done_cycle", 64'(done_cyc), 64'(10 + LAT));
  endtask

  initial begin
    tbl[0].a = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[0].b = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    tbl[0].c = {16'd90, 16'd114, 16'd138, 16'd54, 16'd69, 16'd84, 16'd18, 16'd24, 16'd30};
    tbl[1].a = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    tbl[1].b = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[1].c = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[2].a = {9{16'hFFFF}};
    tbl[2].b = {9{16'hFFFF}};
    tbl[2].c = {9{16'd3}};
    for (int n = 0; n < 9; n++) begin ma[n] = '0; mb[n] = '0; mc[n] = '0; end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dp", {dp_col_a, dp_col_b, dp_col_c, 16'd0}, 64'd0);
    check_c("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int e = 0; e < 3; e++) begin
      for (int n = 0; n < 9; n++) begin ma[n] = tbl[e].a[n]; mb[n] = tbl[e].b[n]; end
      load_model();
      run(0, 0, 0, e == 1);
      for (int n = 0; n < 9; n++) begin
        rd_addr = 4'(n); #1;
        chk($sformatf("tbl%0d_c%0d", e, n), 64'(rd_data), 64'(tbl[e].c[n]));
      end
    end

    // Restart in cycle 4 and a dropped write in cycle 5
    for (int n = 0; n < 9; n++) begin ma[n] = tbl[0].a[n]; mb[n] = tbl[0].b[n]; end
    load_model();
    run(4, 5, 0, 1'b0);
    check_c("restart");
    run(0, 0, 0, 1'b0);
    check_c("rerun");

    // Reset in cycle 6 aborts with everything cleared
    run(0, 0, 6, 1'b0);
    check_c("abort");

    // Same-cycle write and start: B[0][0]=2 reaches the run
    for (int n = 0; n < 9; n++) begin ma[n] = DW'(n + 1); mb[n] = (n % 4 == 0) ? 16'd1 : 16'd0; end
    load_model();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'd2; mb[0] = 16'd2;
    model_product();
    run(0, 0, 0, 1'b0);
    rd_addr = 4'd0; #1;
    chk("same_cycle_c0", 64'(rd_data), 64'd2);
    check_c("same_cycle");

`ifdef PERKALIAN_ACC_EN
    for (int n = 0; n < 9; n++) begin ma[n] = tbl[0].a[n]; mb[n] = tbl[0].b[n]; end
    load_model();
    run(0, 0, 0, 1'b0);
    acc_mode = 1'b1;
    run(0, 0, 0, 1'b0);
    acc_mode = 1'b0;
    for (int n = 0; n < 9; n++) mc[n] = DW'(2 * tbl[0].c[n]);
    check_c("acc");
`endif

    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 9; n++) begin
        ma[n] = DW'($urandom);
        mb[n] = (r == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      end
      load_model();
      wr(5'($urandom_range(18, 31)), DW'($urandom));
      run(0, 0, 0, 1'b0);
      check_c($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
